// File: rtl/prog_loader.sv
// Byte-stream program loader: assembles 16-bit words (high byte first) into instruction memory
// and holds the CPU in reset until a full image lands. Define PROG_LOADER_CHECKSUM_EN for XOR check.
module prog_loader #(
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned ROM_WIDTH  = 16,
  parameter int unsigned PC_WIDTH   = 5
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic                  LOAD,
  input  logic [DATA_WIDTH-1:0] IN_DATA,
  input  logic                  IN_VALID,
  output logic                  IN_READY,
  output logic [PC_WIDTH-1:0]   WR_ADDR,
  output logic [ROM_WIDTH-1:0]  WR_DATA,
  output logic                  WR_EN,
  output logic                  CPU_RST,
  output logic                  BUSY,
  output logic                  DONE,
  output logic                  ERR
);

  localparam int unsigned Depth    = 2 ** PC_WIDTH;
  // One extra bit so a full-depth image reaches len without wrapping the address.
  localparam int unsigned CntWidth = PC_WIDTH + 1;
  localparam logic [DATA_WIDTH-1:0] MaxLen = DATA_WIDTH'(Depth);

  typedef enum logic [2:0] {
    StIdle = 3'd0,
    StLen  = 3'd1,
    StHi   = 3'd2,
    StLo   = 3'd3,
    StWr   = 3'd4,
    StDone = 3'd5,
    StErr  = 3'd6
`ifdef PROG_LOADER_CHECKSUM_EN
    , StChk = 3'd7
`endif
  } state_e;

  state_e                state_q;
  logic [CntWidth-1:0]   cnt_q;
  logic [DATA_WIDTH-1:0] len_q;
  logic [ROM_WIDTH-1:0]  word_q;
`ifdef PROG_LOADER_CHECKSUM_EN
  logic [DATA_WIDTH-1:0] csum_q;
`endif

  logic                xfer;
  logic                len_ok;
  logic [CntWidth-1:0] cnt_inc;
  logic                last_word;

  assign xfer      = IN_VALID & IN_READY;
  assign len_ok    = (IN_DATA != '0) && (IN_DATA <= MaxLen);
  assign cnt_inc   = cnt_q + CntWidth'(1);
  assign last_word = (DATA_WIDTH'(cnt_inc) == len_q);

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      len_q   <= '0;
      word_q  <= '0;
`ifdef PROG_LOADER_CHECKSUM_EN
      csum_q  <= '0;
`endif
    end else begin
      unique case (state_q)
        StIdle, StDone, StErr: begin
          if (LOAD) begin
            state_q <= StLen;
`ifdef PROG_LOADER_CHECKSUM_EN
            csum_q  <= '0;
`endif
          end
        end
        StLen: begin
          if (xfer) begin
            len_q   <= IN_DATA;
            cnt_q   <= '0;
            state_q <= len_ok ? StHi : StErr;
`ifdef PROG_LOADER_CHECKSUM_EN
            csum_q  <= csum_q ^ IN_DATA;
`endif
          end
        end
        StHi: begin
          if (xfer) begin
            word_q[ROM_WIDTH-1 -: DATA_WIDTH] <= IN_DATA;
            state_q <= StLo;
`ifdef PROG_LOADER_CHECKSUM_EN
            csum_q  <= csum_q ^ IN_DATA;
`endif
          end
        end
        StLo: begin
          if (xfer) begin
            word_q[DATA_WIDTH-1:0] <= IN_DATA;
            state_q <= StWr;
`ifdef PROG_LOADER_CHECKSUM_EN
            csum_q  <= csum_q ^ IN_DATA;
`endif
          end
        end
        StWr: begin
          cnt_q <= cnt_inc;
          if (last_word) begin
`ifdef PROG_LOADER_CHECKSUM_EN
            state_q <= StChk;
`else
            state_q <= StDone;
`endif
          end else begin
            state_q <= StHi;
          end
        end
`ifdef PROG_LOADER_CHECKSUM_EN
        StChk: begin
          if (xfer) begin
            state_q <= (IN_DATA == csum_q) ? StDone : StErr;
          end
        end
`endif
        default: state_q <= StIdle;
      endcase
    end
  end

  // Handshake and status are pure state decodes: no path from IN_VALID to IN_READY.
  always_comb begin
    IN_READY = 1'b0;
    WR_EN    = 1'b0;
    BUSY     = 1'b1;
    DONE     = 1'b0;
    ERR      = 1'b0;
    unique case (state_q)
      StIdle:            BUSY = 1'b0;
      StLen, StHi, StLo: IN_READY = 1'b1;
      StWr:              WR_EN = 1'b1;
      StDone: begin
        BUSY = 1'b0;
        DONE = 1'b1;
      end
      StErr: begin
        BUSY = 1'b0;
        ERR  = 1'b1;
      end
`ifdef PROG_LOADER_CHECKSUM_EN
      StChk:             IN_READY = 1'b1;
`endif
      default:           BUSY = 1'b0;
    endcase
  end

  assign CPU_RST = (state_q != StDone);
  assign WR_ADDR = cnt_q[PC_WIDTH-1:0];
  assign WR_DATA = word_q;

`ifndef SYNTHESIS
  a_wr_single: assert property (@(posedge CLK) disable iff (RST) WR_EN |=> !WR_EN);
  a_cnt_bound: assert property (@(posedge CLK) disable iff (RST) cnt_q <= CntWidth'(Depth));
  a_wr_no_rdy: assert property (@(posedge CLK) disable iff (RST) WR_EN |-> !IN_READY);
`endif

endmodule

// File: tb/tb_prog_loader.sv
// Scoreboard bench for prog_loader: stimulus pushes expected writes/outcomes, a monitor pops them.
module tb_prog_loader;

  typedef logic [7:0] bq_t[$];

  logic        clk = 1'b0;
  logic        rst;
  logic        load;
  logic [7:0]  in_data;
  logic        in_valid;
  logic        in_ready;
  logic [4:0]  wr_addr;
  logic [15:0] wr_data;
  logic        wr_en;
  logic        cpu_rst;
  logic        busy;
  logic        done;
  logic        err;

  prog_loader dut (
    .CLK     (clk),
    .RST     (rst),
    .LOAD    (load),
    .IN_DATA (in_data),
    .IN_VALID(in_valid),
    .IN_READY(in_ready),
    .WR_ADDR (wr_addr),
    .WR_DATA (wr_data),
    .WR_EN   (wr_en),
    .CPU_RST (cpu_rst),
    .BUSY    (busy),
    .DONE    (done),
    .ERR     (err)
  );

  always #5 clk = ~clk;

  int n_cmp  = 0;
  int n_fail = 0;

  logic [20:0] wr_q[$];   // {addr, data}
  logic [2:0]  out_q[$];  // {done, err, cpu_rst} once busy drops
  logic [15:0] mem [32];  // instruction memory as written by the DUT
  logic [15:0] mem_exp [32];
  bit          mon_en = 1'b0;
  bit          prev_busy = 1'b0;
  int          cyc = 0;
  int          last_wr_cyc = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    cyc++;
    if (mon_en) begin
      if (wr_en) begin
        mem[wr_addr] = wr_data;
        last_wr_cyc  = cyc;
        if (wr_q.size() == 0) begin
          check("unexpected_write", {11'h0, wr_addr, wr_data}, 32'hffff_ffff);
        end else begin
          check("write", {11'h0, wr_addr, wr_data}, {11'h0, wr_q.pop_front()});
        end
      end
      if (prev_busy && !busy) begin
        if (out_q.size() == 0) begin
          check("unexpected_end", {29'h0, done, err, cpu_rst}, 32'hffff_ffff);
        end else begin
          check("outcome", {29'h0, done, err, cpu_rst}, {29'h0, out_q.pop_front()});
`ifndef PROG_LOADER_CHECKSUM_EN
          if (done) check("done_latency", cyc - last_wr_cyc, 1);
`endif
        end
      end
      prev_busy = busy;
    end
  end

  task automatic send_byte(input logic [7:0] b, input bit gaps);
    int n = 0;
    bit sent = 1'b0;
    while (!sent) begin
      @(negedge clk);
      if (gaps && $urandom_range(0, 2) == 0) begin
        in_valid = 1'b0;
        in_data  = 8'($urandom);
      end else begin
        in_valid = 1'b1;
        in_data  = b;
        if (in_ready) begin
          @(posedge clk);
          sent = 1'b1;
        end
      end
      n++;
      if (!sent && n > 200) begin
        check("send_timeout", 0, 1);
        return;
      end
    end
  endtask

  task automatic pulse_load();
    @(negedge clk);
    in_valid = 1'b0;
    load     = 1'b1;
    @(negedge clk);
    load     = 1'b0;
  endtask

  task automatic wait_quiet();
    int n = 0;
    @(negedge clk);
    in_valid = 1'b0;
    while ((wr_q.size() != 0 || out_q.size() != 0) && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (n >= 200) check("quiet_timeout", 0, 1);
  endtask

  // Reference: a legal length gets len words at addresses 0.., high byte first; anything else errs.
  task automatic run_image(input logic [7:0] len, input bq_t data, input bit gaps,
                           input bit do_pulse, input bit bad_ck, input logic [7:0] ck_force);
    logic [7:0] x;
    logic [7:0] ck;
    bit         len_ok;
    bit         ok;
    len_ok = (len >= 1) && (len <= 32);
    x  = len;
    ok = len_ok;
    if (len_ok) begin
      for (int i = 0; i < int'(len); i++) begin
        wr_q.push_back({5'(i), data[2*i], data[2*i+1]});
        mem_exp[i] = {data[2*i], data[2*i+1]};
        x = x ^ data[2*i] ^ data[2*i+1];
      end
    end
    ck = bad_ck ? ck_force : x;
`ifdef PROG_LOADER_CHECKSUM_EN
    if (len_ok) ok = (ck == x);
`endif
    out_q.push_back(ok ? 3'b100 : 3'b011);
    if (do_pulse) pulse_load();
    send_byte(len, gaps);
    if (len_ok) begin
      for (int i = 0; i < 2 * int'(len); i++) send_byte(data[i], gaps);
`ifdef PROG_LOADER_CHECKSUM_EN
      send_byte(ck, gaps);
`endif
    end
    wait_quiet();
  endtask

  initial begin
    bq_t        d;
    logic [7:0] len;
    rst      = 1'b1;
    load     = 1'b0;
    in_valid = 1'b0;
    in_data  = 8'h00;
    for (int i = 0; i < 32; i++) begin
      mem[i]     = 16'h0;
      mem_exp[i] = 16'h0;
    end
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("rst_cpu_rst", cpu_rst, 1);
    check("rst_in_ready", in_ready, 0);
    check("rst_done", done, 0);
    check("rst_err", err, 0);
    check("rst_busy", busy, 0);
    check("rst_wr_en", wr_en, 0);
    mon_en = 1'b1;

    // Idle with traffic on the bus: nothing consumed, nothing written.
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      in_valid = 1'($urandom);
      in_data  = 8'($urandom);
      check("idle_ready", in_ready, 0);
    end

    // Two-word image with valid held high.
    d = {};
    d.push_back(8'hA1); d.push_back(8'h05); d.push_back(8'h3C); d.push_back(8'hFF);
    run_image(8'h02, d, 1'b0, 1'b1, 1'b0, 8'h00);
    check("two_done", done, 1);
    check("two_cpu_rst", cpu_rst, 0);

`ifdef PROG_LOADER_CHECKSUM_EN
    run_image(8'h02, d, 1'b0, 1'b1, 1'b1, 8'h00);
    check("ck_bad_err", err, 1);
    check("ck_bad_cpu_rst", cpu_rst, 1);
`endif

    // Full 32-word image with random gaps.
    d = {};
    for (int i = 0; i < 64; i++) d.push_back(8'($urandom));
    run_image(8'h20, d, 1'b1, 1'b1, 1'b0, 8'h00);

    // Bad lengths.
    d = {};
    run_image(8'h00, d, 1'b0, 1'b1, 1'b0, 8'h00);
    check("len0_err", err, 1);
    run_image(8'h21, d, 1'b0, 1'b1, 1'b0, 8'h00);
    check("len33_err", err, 1);

    // Mid-load LOAD is ignored; RST after the 3rd word abandons the load.
    wr_q.push_back({5'd0, 16'h1122});
    wr_q.push_back({5'd1, 16'h3344});
    wr_q.push_back({5'd2, 16'h5566});
    mem_exp[0] = 16'h1122; mem_exp[1] = 16'h3344; mem_exp[2] = 16'h5566;
    pulse_load();
    send_byte(8'h04, 1'b0);
    send_byte(8'h11, 1'b0);
    send_byte(8'h22, 1'b0);
    pulse_load();
    check("mid_load_busy", busy, 1);
    send_byte(8'h33, 1'b0);
    send_byte(8'h44, 1'b0);
    send_byte(8'h55, 1'b1);
    send_byte(8'h66, 1'b1);
    wait_quiet();
    check("mid_still_busy", busy, 1);
    out_q.push_back(3'b001);
    @(negedge clk);
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("mid_rst_busy", busy, 0);
    check("mid_rst_cpu_rst", cpu_rst, 1);
    check("mid_rst_outq", out_q.size(), 0);
    for (int i = 0; i < 3; i++) check("retained", mem[i], mem_exp[i]);

    // Reload from DONE.
    d = {};
    d.push_back(8'hDE); d.push_back(8'hAD);
    run_image(8'h01, d, 1'b0, 1'b1, 1'b0, 8'h00);
    check("pre_reload_done", done, 1);
    @(negedge clk);
    load = 1'b1;
    @(negedge clk);
    load = 1'b0;
    check("reload_cpu_rst", cpu_rst, 1);
    check("reload_done", done, 0);
    d = {};
    d.push_back(8'h12); d.push_back(8'h34);
    run_image(8'h01, d, 1'b0, 1'b0, 1'b0, 8'h00);
    check("reload_mem0", mem[0], 16'h1234);
    check("reload_done2", done, 1);

    // Random images, including illegal lengths and corrupted checksums.
    for (int t = 0; t < 12; t++) begin
      case ($urandom_range(0, 5))
        0:       len = ($urandom_range(0, 1) == 0) ? 8'h00 : 8'($urandom_range(33, 255));
        default: len = 8'($urandom_range(1, 32));
      endcase
      d = {};
      for (int i = 0; i < 64; i++) d.push_back(8'($urandom));
      run_image(len, d, 1'($urandom), 1'b1, ($urandom_range(0, 3) == 0),
                8'($urandom_range(0, 255)));
    end
    for (int i = 0; i < 32; i++) check("final_mem", mem[i], mem_exp[i]);

    check("left_writes", wr_q.size(), 0);
    check("left_outcomes", out_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
